am_seq_ctrl: RTL

- Sequenced, resource-shared AM modulator engine for the DDS signal path. Uses one registered signed 16x16 multiplier, time-multiplexed between the depth multiply and the carrier multiply.
- Uses one iterative restoring divider for the /10 depth scaling, in place of parallel multiplier and divider instances.
- Accepts one carrier/modulating sample pair with a valid/ready handshake and returns one AM sample.
- Sits between the carrier/modulating NCOs and the DAC output register, where the lower area justifies a multi-cycle rate.

---
 rtl/am_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/am_seq_ctrl.sv
// Sequenced AM modulator: one shared signed 16x16 multiplier and an iterative
// restoring /10 divider produce one AM sample per accepted carrier/modulating pair.
module am_seq_ctrl #(
  parameter int unsigned DIV_ITER = 20,
  parameter bit          CLAMP_MA = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] carrier,
  input  logic [15:0] modulated,
  input  logic [3:0]  ma,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] AM_sig,
  output logic        busy
);

  localparam int unsigned CntW  = $clog2(DIV_ITER + 1);
  localparam int unsigned Shift = 32 - DIV_ITER;

  typedef enum logic [2:0] {
    StIdle,
    StMul1,
    StDiv,
    StAdd,
    StMul2,
    StOut
  } state_e;

  state_e state_q, state_d;

  logic signed [15:0] car_q;
  logic signed [15:0] mod_q;
  logic        [3:0]  ma_q;
  logic signed [31:0] p_q;
  logic        [31:0] sh_q;
  logic        [3:0]  rem_q;
  logic               neg_q;
  logic [CntW-1:0]    cnt_q;
  logic signed [15:0] h_q;
  logic        [15:0] am_q;
  logic               out_valid_q;

  logic        [3:0]  ma_eff;
  logic signed [15:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [31:0] mul_p;
  logic        [31:0] abs_p;
  logic        [4:0]  rem_try;
  logic               rem_ge;
  logic        [3:0]  rem_nxt;
  logic        [31:0] d;
  logic        [16:0] sum17;
  logic               unused_bits;

  assign ma_eff = (CLAMP_MA && (ma > 4'd10)) ? 4'd10 : ma;

  // The single multiplier: (modulated_s, ma) in MUL1, (h, carrier_s) in MUL2.
  assign mul_a = (state_q == StMul2) ? h_q   : mod_q;
  assign mul_b = (state_q == StMul2) ? car_q : $signed({12'b0, ma_q});
  assign mul_p = 32'(mul_a) * 32'(mul_b);

  assign abs_p = p_q[31] ? 32'(-p_q) : 32'(p_q);

  // One restoring step: remainder always < 10, so the trial value fits 5 bits.
  assign rem_try = {rem_q, sh_q[31]};
  assign rem_ge  = (rem_try >= 5'd10);
  assign rem_nxt = rem_ge ? 4'(rem_try - 5'd10) : rem_try[3:0];

  assign d     = neg_q ? (~sh_q + 32'd1) : sh_q;
  assign sum17 = {d[31], d[15:0]} + 17'd32767;

  assign unused_bits = ^{d[30:16], sum17[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StMul1;
      StMul1: state_d = StDiv;
      StDiv:  if (cnt_q == CntW'(DIV_ITER)) state_d = StAdd;
      StAdd:  state_d = StMul2;
      StMul2: state_d = StOut;
      StOut:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      car_q       <= '0;
      mod_q       <= '0;
      ma_q        <= '0;
      p_q         <= '0;
      sh_q        <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      h_q         <= '0;
      am_q        <= 16'h8000;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            car_q <= $signed({~carrier[15], carrier[14:0]});
            mod_q <= $signed({~modulated[15], modulated[14:0]});
            ma_q  <= ma_eff;
          end
        end
        StMul1: begin
          p_q   <= mul_p;
          cnt_q <= '0;
        end
        StDiv: begin
          // First DIV cycle loads |p1| left-aligned; quotient bits shift in at the LSB.
          if (cnt_q == '0) begin
            sh_q  <= abs_p << Shift;
            rem_q <= '0;
            neg_q <= p_q[31];
          end else begin
            sh_q  <= {sh_q[30:0], rem_ge};
            rem_q <= rem_nxt;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        StAdd: begin
          h_q <= $signed(sum17[16:1]);
        end
        StMul2: begin
          p_q         <= mul_p;
          am_q        <= {~mul_p[31], mul_p[29:15]};
          out_valid_q <= 1'b1;
        end
        StOut: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign AM_sig    = am_q;

endmodule
